// File: rtl/abs_max_stream.sv
// rtl/abs_max_stream.sv - streaming absolute-maximum finder over blocks of packed sign/exp/mant lanes
// Optional index output guarded by ABS_MAX_STREAM_IDX_EN.
module abs_max_stream #(
  parameter int EXP_WIDTH_I  = 5,
  parameter int MANT_WIDTH_I = 2,
  parameter int LANES        = 4,
  parameter int BLOCK_LEN    = 32,
  localparam int BIT_WIDTH_I = 1 + EXP_WIDTH_I + MANT_WIDTH_I,
  localparam int IDX_W       = (BLOCK_LEN > 1) ? $clog2(BLOCK_LEN) : 1
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  input  logic [LANES*BIT_WIDTH_I-1:0] in_data_i,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
`ifdef ABS_MAX_STREAM_IDX_EN
  output logic [IDX_W-1:0]             out_idx_o,
`endif
  output logic [BIT_WIDTH_I-1:0]       out_max_o
);

  localparam int BEATS  = BLOCK_LEN / LANES;
  localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int MAG_W  = BIT_WIDTH_I - 1;
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

  // Exponent sits above mantissa, so the unsigned low bits order by magnitude directly.
  function automatic logic [MAG_W-1:0] mag(input logic [BIT_WIDTH_I-1:0] v);
    return v[MAG_W-1:0];
  endfunction

  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [BIT_WIDTH_I-1:0] run_max_q, run_max_d;
  logic                   out_valid_q, out_valid_d;
  logic [BIT_WIDTH_I-1:0] out_max_q, out_max_d;
  logic [BIT_WIDTH_I-1:0] beat_max, sel_max;
  logic                   in_fire, last_beat, take_new;
`ifdef ABS_MAX_STREAM_IDX_EN
  logic [IDX_W-1:0]       run_idx_q, run_idx_d;
  logic [IDX_W-1:0]       out_idx_q, out_idx_d;
  logic [IDX_W-1:0]       beat_idx, sel_idx;
  logic [LANE_W-1:0]      beat_lane;
`endif

  assign in_ready_o  = !out_valid_q || out_ready_i;
  assign out_valid_o = out_valid_q;
  assign out_max_o   = out_max_q;
`ifdef ABS_MAX_STREAM_IDX_EN
  assign out_idx_o   = out_idx_q;
`endif

  // Strictly-greater replacement keeps the lowest lane on ties.
  always_comb begin
    beat_max = in_data_i[BIT_WIDTH_I-1:0];
`ifdef ABS_MAX_STREAM_IDX_EN
    beat_lane = '0;
`endif
    for (int k = 1; k < LANES; k++) begin
      if (mag(in_data_i[k*BIT_WIDTH_I +: BIT_WIDTH_I]) > mag(beat_max)) begin
        beat_max = in_data_i[k*BIT_WIDTH_I +: BIT_WIDTH_I];
`ifdef ABS_MAX_STREAM_IDX_EN
        beat_lane = LANE_W'(k);
`endif
      end
    end
  end

  always_comb begin
    in_fire     = in_valid_i && in_ready_o;
    last_beat   = (cnt_q == CNT_W'(BEATS - 1));
    take_new    = (cnt_q == '0) || (mag(beat_max) > mag(run_max_q));
    sel_max     = take_new ? beat_max : run_max_q;
    cnt_d       = cnt_q;
    run_max_d   = run_max_q;
    out_valid_d = out_valid_q;
    out_max_d   = out_max_q;
`ifdef ABS_MAX_STREAM_IDX_EN
    beat_idx  = IDX_W'(int'(cnt_q) * LANES + int'(beat_lane));
    sel_idx   = take_new ? beat_idx : run_idx_q;
    run_idx_d = run_idx_q;
    out_idx_d = out_idx_q;
`endif
    if (out_valid_q && out_ready_i) begin
      out_valid_d = 1'b0;
    end
    if (in_fire) begin
      run_max_d = sel_max;
`ifdef ABS_MAX_STREAM_IDX_EN
      run_idx_d = sel_idx;
`endif
      if (last_beat) begin
        cnt_d       = '0;
        out_valid_d = 1'b1;
        out_max_d   = sel_max;
`ifdef ABS_MAX_STREAM_IDX_EN
        out_idx_d   = sel_idx;
`endif
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q       <= '0;
      run_max_q   <= '0;
      out_valid_q <= 1'b0;
      out_max_q   <= '0;
`ifdef ABS_MAX_STREAM_IDX_EN
      run_idx_q   <= '0;
      out_idx_q   <= '0;
`endif
    end else begin
      cnt_q       <= cnt_d;
      run_max_q   <= run_max_d;
      out_valid_q <= out_valid_d;
      out_max_q   <= out_max_d;
`ifdef ABS_MAX_STREAM_IDX_EN
      run_idx_q   <= run_idx_d;
      out_idx_q   <= out_idx_d;
`endif
    end
  end

endmodule

// File: tb/tb_abs_max_stream.sv
// tb/tb_abs_max_stream.sv - self-checking bench for abs_max_stream (E5M2 and integer-mode instances)
module tb_abs_max_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        a_in_valid, a_out_ready;
  logic [31:0] a_in_data;
  logic        a_in_ready, a_out_valid;
  logic [7:0]  a_out_max;
  logic        b_in_valid, b_out_ready;
  logic [31:0] b_in_data;
  logic        b_in_ready, b_out_valid;
  logic [7:0]  b_out_max;
`ifdef ABS_MAX_STREAM_IDX_EN
  logic [2:0]  a_out_idx, b_out_idx;
`endif

  abs_max_stream #(.EXP_WIDTH_I(5), .MANT_WIDTH_I(2), .LANES(4), .BLOCK_LEN(8)) u_a (
    .clk_i(clk), .rst_ni(rst_n),
    .in_valid_i(a_in_valid), .in_ready_o(a_in_ready), .in_data_i(a_in_data),
    .out_valid_o(a_out_valid), .out_ready_i(a_out_ready),
`ifdef ABS_MAX_STREAM_IDX_EN
    .out_idx_o(a_out_idx),
`endif
    .out_max_o(a_out_max)
  );

  abs_max_stream #(.EXP_WIDTH_I(0), .MANT_WIDTH_I(7), .LANES(4), .BLOCK_LEN(8)) u_b (
    .clk_i(clk), .rst_ni(rst_n),
    .in_valid_i(b_in_valid), .in_ready_o(b_in_ready), .in_data_i(b_in_data),
    .out_valid_o(b_out_valid), .out_ready_i(b_out_ready),
`ifdef ABS_MAX_STREAM_IDX_EN
    .out_idx_o(b_out_idx),
`endif
    .out_max_o(b_out_max)
  );

  int n_pass = 0;
  int n_total = 0;

  logic [7:0] blk[$];
  bit         exp_valid;
  logic [7:0] exp_max;
  int         exp_idx;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] pack(input logic [7:0] l0, l1, l2, l3);
    return {l3, l2, l1, l0};
  endfunction

  function automatic int magn(input logic [7:0] v);
    return int'(v[6:0]);
  endfunction

  // Reference: first element of largest magnitude across the whole block.
  task automatic model_close();
    int best = 0;
    for (int i = 1; i < 8; i++)
      if (magn(blk[i]) > magn(blk[best])) best = i;
    exp_max   = blk[best];
    exp_idx   = best;
    exp_valid = 1'b1;
    blk.delete();
  endtask

  task automatic cycle(input bit vld, input logic [31:0] data, input bit ordy);
    bit rdy;
    a_in_valid  = vld;
    a_in_data   = data;
    a_out_ready = ordy;
    #1;
    rdy = !exp_valid || ordy;
    check("in_ready", {31'b0, a_in_ready}, {31'b0, rdy});
    @(posedge clk);
    if (exp_valid && ordy) exp_valid = 1'b0;
    if (vld && rdy) begin
      for (int k = 0; k < 4; k++) blk.push_back(data[k*8 +: 8]);
      if (blk.size() == 8) model_close();
    end
    #1;
    check("out_valid", {31'b0, a_out_valid}, {31'b0, exp_valid});
    if (exp_valid) begin
      check("out_max", {24'b0, a_out_max}, {24'b0, exp_max});
`ifdef ABS_MAX_STREAM_IDX_EN
      check("out_idx", {29'b0, a_out_idx}, exp_idx);
`endif
    end
  endtask

  task automatic reset_pulse();
    #2;
    rst_n = 1'b0;
    blk.delete();
    exp_valid = 1'b0;
    #2;
    check("rst_out_valid", {31'b0, a_out_valid}, 32'd0);
    check("rst_out_max", {24'b0, a_out_max}, 32'd0);
    rst_n = 1'b1;
  endtask

  function automatic logic [7:0] rnd_lane();
    case ($urandom % 4)
      0: return 8'h44;
      1: return 8'hC4;
      2: return 8'h00;
      default: return 8'($urandom);
    endcase
  endfunction

  initial begin
    rst_n = 1'b0;
    a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0;
    exp_valid = 1'b0;
    exp_max = '0;
    exp_idx = 0;

    #12;
    check("reset_valid", {31'b0, a_out_valid}, 32'd0);
    check("reset_max", {24'b0, a_out_max}, 32'd0);
    check("reset_ready", {31'b0, a_in_ready}, 32'd1);
    check("reset_b_valid", {31'b0, b_out_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_reset_valid", {31'b0, a_out_valid}, 32'd0);
    check("post_reset_ready", {31'b0, a_in_ready}, 32'd1);

    cycle(1'b1, pack(8'h3C, 8'hBD, 8'h40, 8'h01), 1'b1);
    cycle(1'b1, pack(8'h10, 8'h20, 8'h30, 8'h3F), 1'b1);
    check("basic_max", {24'b0, a_out_max}, 32'h40);
`ifdef ABS_MAX_STREAM_IDX_EN
    check("basic_idx", {29'b0, a_out_idx}, 32'd2);
`endif

    repeat (5) cycle(1'b1, pack(8'h44, 8'h00, 8'hC4, 8'h00), 1'b0);
    check("held_max", {24'b0, a_out_max}, 32'h40);
    cycle(1'b1, pack(8'h44, 8'h00, 8'hC4, 8'h00), 1'b1);
    cycle(1'b1, pack(8'hC4, 8'h44, 8'h00, 8'h00), 1'b1);
    check("tie_max", {24'b0, a_out_max}, 32'h44);
`ifdef ABS_MAX_STREAM_IDX_EN
    check("tie_idx", {29'b0, a_out_idx}, 32'd0);
`endif

    cycle(1'b1, pack(8'h7F, 8'h7E, 8'h7D, 8'h7C), 1'b1);
    reset_pulse();
    cycle(1'b1, pack(8'h01, 8'h00, 8'h00, 8'h00), 1'b1);
    cycle(1'b1, pack(8'h00, 8'h00, 8'h00, 8'h02), 1'b1);
    check("rst_mid_max", {24'b0, a_out_max}, 32'h02);
`ifdef ABS_MAX_STREAM_IDX_EN
    check("rst_mid_idx", {29'b0, a_out_idx}, 32'd7);
`endif

    repeat (300)
      cycle(($urandom % 4) != 0, pack(rnd_lane(), rnd_lane(), rnd_lane(), rnd_lane()),
            ($urandom % 4) != 0);
    repeat (2) cycle(1'b0, 32'd0, 1'b1);

    b_out_ready = 1'b1;
    b_in_valid  = 1'b1;
    b_in_data   = pack(8'h85, 8'h06, 8'h00, 8'h00);
    #1;
    check("int_ready", {31'b0, b_in_ready}, 32'd1);
    @(posedge clk);
    #1;
    b_in_data = pack(8'h86, 8'h00, 8'h00, 8'h00);
    @(posedge clk);
    #1;
    b_in_valid = 1'b0;
    check("int_valid", {31'b0, b_out_valid}, 32'd1);
    check("int_max", {24'b0, b_out_max}, 32'h06);
`ifdef ABS_MAX_STREAM_IDX_EN
    check("int_idx", {29'b0, b_out_idx}, 32'd1);
`endif
    @(posedge clk);
    #1;
    check("int_pop", {31'b0, b_out_valid}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
